overlay_draw_scheduler: RTL and testbench

Request-driven scheduler for the shared overlay draw engine, the clear/ascii_draw/rect_draw datapath that writes the two-bank overlay RAM. It replaces fixed frame-counter time slots. Up to N_REQ sources (face rectangles, probability labels, variable text, constant text) present draw commands over valid/ready. The block clears the inactive RAM bank at each frame start, then grants the engine round-robin, one command at a time, and flags frames whose work did not finish before the next vsync.

---
 rtl/overlay_draw_scheduler_pkg.sv | 54 +++++
 rtl/overlay_draw_scheduler_rr_arbiter.sv | 45 ++++
 rtl/overlay_draw_scheduler.sv | 157 +++++++++++++++
 tb/tb_overlay_draw_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_draw_scheduler_pkg.sv
// Shared definitions for the overlay draw scheduler: op codes, command field
// offsets, clear row bounds per bank, and the FSM state type.
package overlay_draw_scheduler_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_ASCII = 2'b01;
  localparam logic [1:0] OP_RECT  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // Rows cleared when preparing each bank for drawing.
  localparam int BANK0_Y1 = 128;
  localparam int BANK0_Y2 = 191;
  localparam int BANK1_Y1 = 0;
  localparam int BANK1_Y2 = 127;

  // Command layout, LSB first: y2, x2, y1, x1, ascii, color, op.
  function automatic int ofs_x2(input int l_w);
    return l_w;
  endfunction

  function automatic int ofs_y1(input int l_w);
    return 2 * l_w;
  endfunction

  function automatic int ofs_x1(input int l_w);
    return 3 * l_w;
  endfunction

  function automatic int ofs_ascii(input int l_w);
    return 4 * l_w;
  endfunction

  function automatic int ofs_color(input int l_w, input int a_w);
    return 4 * l_w + a_w;
  endfunction

  function automatic int ofs_op(input int l_w, input int a_w);
    return 4 * l_w + a_w + 3;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hff) ? v + 8'd1 : v;
  endfunction

  // ST_CLEAR is reserved; a clear travels through ISSUE/WAIT_DONE like any command.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/overlay_draw_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer wins; the pointer
// moves past the winner whenever the grant is taken.
module rr_arbiter_n #(
  parameter int N = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    // Walk downwards so the smallest offset from ptr is assigned last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        grant_idx = cand;
        any       = 1'b1;
      end
    end
    grant = any ? (N'(1) << grant_idx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/overlay_draw_scheduler.sv
// Request-driven scheduler for the shared overlay draw engine: clears the
// inactive bank at each frame start, then serves requesters round-robin.
module overlay_draw_scheduler
  import overlay_draw_scheduler_pkg::*;
#(
  parameter int L_W   = 8,
  parameter int A_W   = 8,
  parameter int N_REQ = 4,
  parameter int CMD_W = 2 + 3 + A_W + 4 * L_W
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   i_vs,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*CMD_W-1:0] i_req_cmd,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_eng_valid,
  input  logic                   i_eng_ready,
  input  logic                   i_eng_done,
  output logic [1:0]             o_op,
  output logic [2:0]             o_color,
  output logic [A_W-1:0]         o_ascii,
  output logic [L_W-1:0]         o_x1,
  output logic [L_W-1:0]         o_y1,
  output logic [L_W-1:0]         o_x2,
  output logic [L_W-1:0]         o_y2,
  output logic                   o_bank,
  output logic                   o_overrun,
  output logic [7:0]             o_frame_cmds
);

  localparam int IDX_W     = $clog2(N_REQ);
  localparam int X2_LSB    = ofs_x2(L_W);
  localparam int Y1_LSB    = ofs_y1(L_W);
  localparam int X1_LSB    = ofs_x1(L_W);
  localparam int ASCII_LSB = ofs_ascii(L_W);
  localparam int COLOR_LSB = ofs_color(L_W, A_W);
  localparam int OP_LSB    = ofs_op(L_W, A_W);

  state_t           state;
  logic             vs_q;
  logic             fs_q;
  logic             pending_clear;
  logic [7:0]       run_cnt;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_req;
  logic             idle_like;
  logic             clear_now;
  logic             grant_en;
  logic             busy;
  logic             done_inc;
  logic             next_bank;
  logic [CMD_W-1:0] sel_cmd;

  rr_arbiter_n #(.N(N_REQ)) u_arb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (i_req_valid),
    .advance   (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign idle_like   = (state == ST_IDLE) || (state == ST_ARB);
  assign clear_now   = fs_q || pending_clear;
  // Gated by reset so the accept pulse stays low while the block is held in reset.
  assign grant_en    = sys_rst_n && idle_like && !clear_now && any_req;
  assign o_req_ready = grant_en ? grant : '0;
  assign sel_cmd     = i_req_cmd[int'(grant_idx) * CMD_W +: CMD_W];
  assign busy        = pending_clear ||
                       !((state == ST_IDLE) || (state == ST_ARB && !(|i_req_valid)));
  assign done_inc    = (state == ST_WAIT_DONE) && i_eng_done && (o_op != OP_CLEAR);
  // A clear issued in the frame-start cycle targets the bank being toggled to.
  assign next_bank   = fs_q ? ~o_bank : o_bank;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      vs_q          <= 1'b0;
      fs_q          <= 1'b0;
      pending_clear <= 1'b0;
      run_cnt       <= '0;
      o_eng_valid   <= 1'b0;
      o_op          <= OP_CLEAR;
      o_color       <= '0;
      o_ascii       <= '0;
      o_x1          <= '0;
      o_y1          <= '0;
      o_x2          <= '0;
      o_y2          <= '0;
      o_bank        <= 1'b0;
      o_overrun     <= 1'b0;
      o_frame_cmds  <= '0;
    end else begin
      vs_q <= i_vs;
      fs_q <= i_vs & ~vs_q;

      if (fs_q) begin
        o_bank        <= ~o_bank;
        o_frame_cmds  <= sat_inc(run_cnt, done_inc);
        run_cnt       <= '0;
        o_overrun     <= busy;
        pending_clear <= 1'b1;
      end else begin
        run_cnt <= sat_inc(run_cnt, done_inc);
      end

      // The FSM's pending_clear write below overrides the frame-start set above
      // when the clear is issued in that same cycle (last non-blocking write wins).
      case (state)
        ST_IDLE, ST_ARB: begin
          if (clear_now) begin
            pending_clear <= 1'b0;
            state         <= ST_ISSUE;
            o_eng_valid   <= 1'b1;
            o_op          <= OP_CLEAR;
            o_color       <= '0;
            o_ascii       <= '0;
            o_x1          <= '0;
            o_x2          <= '1;
            o_y1          <= next_bank ? L_W'(BANK1_Y1) : L_W'(BANK0_Y1);
            o_y2          <= next_bank ? L_W'(BANK1_Y2) : L_W'(BANK0_Y2);
          end else if (grant_en) begin
            if (sel_cmd[OP_LSB +: 2] == OP_RSVD) begin
              state <= ST_ARB;
            end else begin
              state       <= ST_ISSUE;
              o_eng_valid <= 1'b1;
              o_op        <= sel_cmd[OP_LSB +: 2];
              o_color     <= sel_cmd[COLOR_LSB +: 3];
              o_ascii     <= sel_cmd[ASCII_LSB +: A_W];
              o_x1        <= sel_cmd[X1_LSB +: L_W];
              o_y1        <= sel_cmd[Y1_LSB +: L_W];
              o_x2        <= sel_cmd[X2_LSB +: L_W];
              o_y2        <= sel_cmd[0 +: L_W];
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (i_eng_ready) begin
            o_eng_valid <= 1'b0;
            state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i_eng_done) state <= ST_ARB;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_overlay_draw_scheduler.sv
// Directed bench for overlay_draw_scheduler: a vector table for arbitration
// plus hand-written frame-start, overrun, saturation and reset sequences.
module tb_overlay_draw_scheduler;

  localparam int L_W   = 8;
  localparam int A_W   = 8;
  localparam int N_REQ = 4;
  localparam int CMD_W = 2 + 3 + A_W + 4 * L_W;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_ASCII = 2'b01;
  localparam logic [1:0] C_RECT  = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  typedef struct {
    logic [3:0] valid;
    logic [1:0] op;
    int         exp_idx;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   i_vs = 1'b0;
  logic [N_REQ-1:0]       i_req_valid = '0;
  logic [N_REQ*CMD_W-1:0] i_req_cmd = '0;
  logic                   i_eng_ready = 1'b0;
  logic                   i_eng_done = 1'b0;
  logic [N_REQ-1:0]       o_req_ready;
  logic                   o_eng_valid;
  logic [1:0]             o_op;
  logic [2:0]             o_color;
  logic [A_W-1:0]         o_ascii;
  logic [L_W-1:0]         o_x1, o_y1, o_x2, o_y2;
  logic                   o_bank;
  logic                   o_overrun;
  logic [7:0]             o_frame_cmds;
  logic [CMD_W-1:0]       out_cmd;

  int n_pass = 0;
  int n_total = 0;
  int ack_count = 0;

  overlay_draw_scheduler #(.L_W(L_W), .A_W(A_W), .N_REQ(N_REQ)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .i_vs         (i_vs),
    .i_req_valid  (i_req_valid),
    .i_req_cmd    (i_req_cmd),
    .o_req_ready  (o_req_ready),
    .o_eng_valid  (o_eng_valid),
    .i_eng_ready  (i_eng_ready),
    .i_eng_done   (i_eng_done),
    .o_op         (o_op),
    .o_color      (o_color),
    .o_ascii      (o_ascii),
    .o_x1         (o_x1),
    .o_y1         (o_y1),
    .o_x2         (o_x2),
    .o_y2         (o_y2),
    .o_bank       (o_bank),
    .o_overrun    (o_overrun),
    .o_frame_cmds (o_frame_cmds)
  );

  assign out_cmd = {o_op, o_color, o_ascii, o_x1, o_y1, o_x2, o_y2};

  always #5 clk = ~clk;

  always @(negedge clk) ack_count = ack_count + $countones(o_req_ready);

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op, input logic [2:0] c,
                                              input logic [7:0] a, input logic [7:0] x1,
                                              input logic [7:0] y1, input logic [7:0] x2,
                                              input logic [7:0] y2);
    return {op, c, a, x1, y1, x2, y2};
  endfunction

  function automatic logic [CMD_W-1:0] base_cmd(input int k, input logic [1:0] op);
    return mk_cmd(op, 3'(k + 1), 8'(8'h41 + k), 8'(16 * k + 3), 8'(k + 5),
                  8'(16 * k + 40), 8'(k + 60));
  endfunction

  function automatic logic [CMD_W-1:0] clear_cmd(input logic bank);
    return bank ? mk_cmd(C_CLEAR, 3'd0, 8'd0, 8'd0, 8'd0, 8'hff, 8'd127)
                : mk_cmd(C_CLEAR, 3'd0, 8'd0, 8'd0, 8'd128, 8'hff, 8'd191);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmds(input logic [1:0] op);
    for (int k = 0; k < N_REQ; k++) i_req_cmd[k*CMD_W +: CMD_W] = base_cmd(k, op);
  endtask

  // Accept the pending command, then pulse done after lat idle cycles.
  task automatic serve(input int lat);
    i_eng_ready = 1'b1;
    step();
    i_eng_ready = 1'b0;
    repeat (lat) step();
    i_eng_done = 1'b1;
    step();
    i_eng_done = 1'b0;
  endtask

  task automatic wait_eng_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!o_eng_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(o_eng_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    int   cont_exp[4];
    int   a0;
    int   stable;
    int   w;
    logic [CMD_W-1:0] exp_cmd;

    cont_exp = '{0, 2, 0, 2};
    // Pointer is 3 when the table starts (after the 0,2,0,2 sequence).
    vecs[0]  = '{4'b0101, C_ASCII, 0};
    vecs[1]  = '{4'b0101, C_RECT,  2};
    vecs[2]  = '{4'b1000, C_ASCII, 3};
    vecs[3]  = '{4'b1111, C_RECT,  0};
    vecs[4]  = '{4'b1110, C_ASCII, 1};
    vecs[5]  = '{4'b0010, C_RECT,  1};
    vecs[6]  = '{4'b1011, C_ASCII, 3};
    vecs[7]  = '{4'b0110, C_RECT,  1};
    vecs[8]  = '{4'b0001, C_ASCII, 0};
    vecs[9]  = '{4'b0001, C_RSVD,  0};
    vecs[10] = '{4'b0011, C_RECT,  1};

    // Reset state
    #2;
    check("reset eng_valid", 64'(o_eng_valid), 64'd0);
    check("reset bank", 64'(o_bank), 64'd0);
    check("reset overrun", 64'(o_overrun), 64'd0);
    check("reset frame_cmds", 64'(o_frame_cmds), 64'd0);
    check("reset cmd", 64'(out_cmd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First frame start: clear of bank 1
    i_vs = 1'b1;
    step();
    @(negedge clk);
    check("fs detect cycle no valid", 64'(o_eng_valid), 64'd0);
    step();
    @(negedge clk);
    check("clear1 valid+cmd", {15'd0, o_eng_valid, out_cmd}, {15'd0, 1'b1, clear_cmd(1'b1)});
    check("clear1 bank", 64'(o_bank), 64'd1);
    check("clear1 overrun", 64'(o_overrun), 64'd0);
    serve(2);
    i_vs = 1'b0;
    @(negedge clk);
    check("after clear1 frame_cmds", 64'(o_frame_cmds), 64'd0);
    check("after clear1 idle", 64'(o_eng_valid), 64'd0);
    step();

    // Requesters 0 and 2 continuously valid
    set_cmds(C_ASCII);
    i_req_valid = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      @(negedge clk);
      while (o_req_ready == '0 && w < 8) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("cont%0d ready", n), 64'(o_req_ready), 64'(4'(1) << cont_exp[n]));
      step();
      @(negedge clk);
      check($sformatf("cont%0d pulse", n), 64'(o_req_ready), 64'd0);
      check($sformatf("cont%0d cmd", n), 64'(out_cmd), 64'(base_cmd(cont_exp[n], C_ASCII)));
      serve(1);
    end
    i_req_valid = '0;

    // Table-driven arbitration vectors
    for (int i = 0; i < 11; i++) begin
      set_cmds(vecs[i].op);
      i_req_valid = vecs[i].valid;
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 64'(o_req_ready), 64'(4'(1) << vecs[i].exp_idx));
      step();
      i_req_valid = '0;
      @(negedge clk);
      if (vecs[i].op == C_RSVD) begin
        check($sformatf("vec%0d dropped", i), 64'(o_eng_valid), 64'd0);
        step();
      end else begin
        check($sformatf("vec%0d valid+cmd", i), {15'd0, o_eng_valid, out_cmd},
              {15'd0, 1'b1, base_cmd(vecs[i].exp_idx, vecs[i].op)});
        serve(1);
      end
    end

    // Engine stalls for 5 cycles
    set_cmds(C_RECT);
    a0 = ack_count;
    i_req_valid = 4'b0001;
    @(negedge clk);
    check("hold ready", 64'(o_req_ready), 64'd1);
    step();
    i_req_valid = '0;
    exp_cmd = base_cmd(0, C_RECT);
    @(negedge clk);
    check("hold first", {15'd0, o_eng_valid, out_cmd}, {15'd0, 1'b1, exp_cmd});
    stable = 0;
    repeat (5) begin
      step();
      @(negedge clk);
      if (o_eng_valid && out_cmd == exp_cmd) stable++;
    end
    check("hold stable cycles", 64'(stable), 64'd5);
    serve(1);
    @(negedge clk);
    check("hold acks", 64'(ack_count - a0), 64'd1);
    step();

    // Frame start during WAIT_DONE of a rect
    set_cmds(C_RECT);
    i_req_valid = 4'b0100;
    @(negedge clk);
    check("ovr ready", 64'(o_req_ready), 64'b0100);
    step();
    i_req_valid = '0;
    @(negedge clk);
    check("ovr issue", 64'(o_eng_valid), 64'd1);
    i_eng_ready = 1'b1;
    step();
    i_eng_ready = 1'b0;
    i_vs = 1'b1;
    step();
    step();
    @(negedge clk);
    check("ovr overrun", 64'(o_overrun), 64'd1);
    check("ovr frame_cmds", 64'(o_frame_cmds), 64'd15);
    check("ovr bank", 64'(o_bank), 64'd0);
    check("ovr not aborted", 64'(o_eng_valid), 64'd0);
    i_eng_done = 1'b1;
    step();
    i_eng_done = 1'b0;
    @(negedge clk);
    check("ovr arb gap", 64'(o_eng_valid), 64'd0);
    step();
    @(negedge clk);
    check("ovr clear bank0", {15'd0, o_eng_valid, out_cmd}, {15'd0, 1'b1, clear_cmd(1'b0)});
    serve(0);
    i_vs = 1'b0;

    // 300 ascii commands in one frame
    set_cmds(C_ASCII);
    a0 = ack_count;
    i_req_valid = 4'b0001;
    for (int n = 0; n < 300; n++) begin
      wait_eng_valid($sformatf("sat cmd%0d valid", n));
      serve(0);
    end
    i_req_valid = '0;
    step();
    @(negedge clk);
    check("sat acks", 64'(ack_count - a0), 64'd300);
    i_vs = 1'b1;
    step();
    step();
    @(negedge clk);
    check("sat frame_cmds", 64'(o_frame_cmds), 64'd255);
    check("sat overrun cleared", 64'(o_overrun), 64'd0);
    check("sat clear bank1", {15'd0, o_eng_valid, out_cmd}, {15'd0, 1'b1, clear_cmd(1'b1)});

    // Reset while the clear sits in ISSUE
    rst_n = 1'b0;
    #1;
    check("rst eng_valid", 64'(o_eng_valid), 64'd0);
    check("rst bank", 64'(o_bank), 64'd0);
    check("rst frame_cmds", 64'(o_frame_cmds), 64'd0);
    check("rst cmd", 64'(out_cmd), 64'd0);
    i_vs = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Frame start coinciding with a request: the clear wins
    i_vs = 1'b1;
    step();
    set_cmds(C_ASCII);
    i_req_valid = 4'b0010;
    @(negedge clk);
    check("fs vs req no ack", 64'(o_req_ready), 64'd0);
    step();
    @(negedge clk);
    check("post-rst clear", {15'd0, o_eng_valid, out_cmd}, {15'd0, 1'b1, clear_cmd(1'b1)});
    check("post-rst bank", 64'(o_bank), 64'd1);
    serve(1);
    @(negedge clk);
    check("post-clear ack", 64'(o_req_ready), 64'b0010);
    step();
    i_req_valid = '0;
    @(negedge clk);
    check("post-clear cmd", {15'd0, o_eng_valid, out_cmd}, {15'd0, 1'b1, base_cmd(1, C_ASCII)});
    serve(1);
    i_vs = 1'b0;
    step();
    step();
    @(negedge clk);
    check("end frame_cmds", 64'(o_frame_cmds), 64'd0);
    check("end idle", 64'(o_eng_valid), 64'd0);
    check("end overrun", 64'(o_overrun), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
